ascon_permutation_iter: RTL and testbench
=========================================

Name: ascon_permutation_iter

Overview:
Iterative, parametrised Ascon permutation engine applying p^a to a 320-bit state, with a = 12, 8 or 6 selected per transaction at runtime. It instantiates UNROLL round stages and loops the state register through them, trading area against latency. Valid/ready handshakes sit on both input and output. It is the shared permutation resource for the AEAD/hash controller that sequences initialisation, absorb and finalisation.

Parameters:
UNROLL, 1, rounds computed per clock cycle; legal values are 1, 2, 3 and 4; any other value is an elaboration error.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous active-high reset
in_valid_i  in  1  input state and round selection are valid
in_ready_o  out  1  engine can accept a new state
rounds_sel_i  in  2  00: 12 rounds; 01: 8 rounds; 10: 6 rounds; 11: treated as 12
x0_i..x4_i  in  64 each  input state words
out_valid_o  out  1  result held on x*_o
out_ready_i  in  1  consumer accepts the result
x0_o..x4_o  out  64 each  permuted state words, driven directly from the state register
busy_o  out  1  high in RUN

Behaviour:
- Reset (asynchronous, immediate): state is IDLE, state register = 0, round counter = 0, out_valid_o = 0, busy_o = 0, in_ready_o = 1, x*_o = 0.
- Round function, per round r: p_C (x2 ^= rc) -> 5-bit chi-style S-box -> linear layer.
  - Linear layer rotations: x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
  - Round constant: rc = {56'b0, (4'hF - r[3:0]), r[3:0]}, with r in 0..11 in 12-round numbering.
  - For a rounds, r starts at 12 - a and increments by one per round executed.
- State IDLE:
  - in_ready_o = 1.
  - On in_valid_i & in_ready_o: load x*_i into the state, load r = 12 - a, load remaining = a, go to RUN.
  - No rounds are computed on the accept edge.
- State RUN:
  - busy_o = 1, in_ready_o = 0.
  - Each cycle executes k = min(UNROLL, remaining) rounds. Unused trailing stages are bypassed, so their outputs are not registered.
  - After each cycle: r += k, remaining -= k.
  - When remaining reaches 0 at the end of a cycle, go to DONE.
- Latency: out_valid_o rises ceil(a/UNROLL) cycles after the accept edge.
  - UNROLL = 1: 12, 8 or 6 cycles.
  - UNROLL = 3: 4, 3 or 2 cycles.
  - UNROLL = 4: 3, 2 or 2 cycles; for a = 6 the second cycle executes only 2 rounds.
- State DONE:
  - out_valid_o = 1; x*_o are stable until the output handshake completes.
  - out_valid_o must not drop without out_ready_i.
  - On out_valid_o & out_ready_i: go to IDLE, and out_valid_o = 0 in the next cycle.
- Back-to-back transactions:
  - in_ready_o = 1 in DONE when out_ready_i = 1.
  - A simultaneous output handshake and input accept loads the new state and goes directly to RUN, with no IDLE bubble.
- rounds_sel_i is sampled only on the accept edge. Changes to it during RUN have no effect.
- in_valid_i while not ready is ignored. The upstream side holds its data until it sees in_ready_o.
- Reset asserted mid-RUN or mid-DONE: the transaction is discarded and all outputs return to their reset values immediately. No partial result is ever flagged valid.
- State and round-counter registers are the only storage. No input or output skid buffer.

Test Plan:
- UNROLL=1, all-zero state, rounds_sel=00:
  - out_valid_o rises exactly 12 cycles after accept.
  - Result is bit-exact to the software Ascon model p12(0).
- Ascon-128 init state (IV 0x80400c0600000000, key = 0, nonce = 0), rounds_sel=00:
  - UNROLL = 1, 2, 3 and 4 all produce identical outputs, matching the model.
  - Measured latencies are 12, 6, 4 and 3 cycles.
- UNROLL=4, rounds_sel=10, random state:
  - Latency is 2 cycles.
  - Output equals model p6, confirming the partial last step applies only 2 rounds.
- out_ready_i held low for 5 cycles after out_valid_o:
  - x*_o and out_valid_o stay stable.
  - in_ready_o = 0 throughout.
  - Next input is accepted on the cycle out_ready_i rises, with no bubble.
- rounds_sel_i toggled and in_valid_i pulsed during RUN:
  - The result still matches the originally sampled round count.
  - The extra pulse is ignored.
- rst_i asserted in cycle 3 of a p12 run:
  - All outputs are 0 immediately and in_ready_o = 1.
  - After release, a fresh p8 transaction completes correctly.

Source files
------------

// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon permutation p^a (a = 12, 8 or 6) with UNROLL rounds per clock.
// The state register loops through the round stages; valid/ready on both sides.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for an input state, in_ready_o high
//   RUN     | applying min(UNROLL, remaining) rounds per cycle, busy_o high
//   DONE    | result held on x*_o with out_valid_o until out_ready_i
module ascon_permutation_iter #(
    parameter int UNROLL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  rounds_sel_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic        busy_o
);

    if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
        $error("ascon_permutation_iter: UNROLL must be 1, 2, 3 or 4");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fsm_e;

    localparam logic [3:0] UNROLL_W = 4'(UNROLL);

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, 4'hF - r, r};
        // bit-sliced 5-bit S-box
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    fsm_e           fsm_q, fsm_d;
    logic [319:0]   state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [3:0]     remaining_q, remaining_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;

    logic [3:0]     sel_rounds;
    logic [3:0]     step;
    logic [319:0]   round_out;
    logic           accept;

    always_comb begin
        case (rounds_sel_i)
            2'b01:   sel_rounds = 4'd8;
            2'b10:   sel_rounds = 4'd6;
            default: sel_rounds = 4'd12;
        endcase
    end

    assign step = (remaining_q < UNROLL_W) ? remaining_q : UNROLL_W;

    // stages beyond the remaining round count pass the state through untouched
    always_comb begin
        round_out = state_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (4'(i) < remaining_q) begin
                round_out = ascon_round(round_out, round_q + 4'(i));
            end
        end
    end

    assign in_ready_o = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_d     = round_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (fsm_q)
            ST_RUN: begin
                state_d     = round_out;
                round_d     = round_q + step;
                remaining_d = remaining_q - step;
                if (remaining_q == step) begin
                    fsm_d       = ST_DONE;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    fsm_d       = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        // an accept in DONE overrides the return to IDLE: no bubble
        if (accept) begin
            state_d     = {x0_i, x1_i, x2_i, x3_i, x4_i};
            round_d     = 4'd12 - sel_rounds;
            remaining_d = sel_rounds;
            fsm_d       = ST_RUN;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            round_q     <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_q     <= round_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign {x0_o, x1_o, x2_o, x3_o, x4_o} = state_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Directed bench for ascon_permutation_iter: one instance per UNROLL value (1..4)
// share the input bus; results are compared against a table-driven Ascon model.
module tb_ascon_permutation_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  sel;
    logic [63:0] xi [5];

    logic        in_ready  [4];
    logic        out_valid [4];
    logic        busy      [4];
    logic [63:0] xo [4][5];

    int n_vec = 0;
    int n_err = 0;
    int lat [4];
    logic [319:0] got [4];

    logic [7:0] sbox_t [32] = '{
        8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
        8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
        8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
        8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ascon_permutation_iter #(.UNROLL(g + 1)) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .in_valid_i   (in_valid),
            .in_ready_o   (in_ready[g]),
            .rounds_sel_i (sel),
            .x0_i         (xi[0]),
            .x1_i         (xi[1]),
            .x2_i         (xi[2]),
            .x3_i         (xi[3]),
            .x4_i         (xi[4]),
            .out_valid_o  (out_valid[g]),
            .out_ready_i  (out_ready),
            .x0_o         (xo[g][0]),
            .x1_o         (xo[g][1]),
            .x2_o         (xo[g][2]),
            .x3_o         (xo[g][3]),
            .x4_o         (xo[g][4]),
            .busy_o       (busy[g])
        );
    end

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // column-wise S-box lookup, then the linear layer
    function automatic logic [319:0] model_perm(input logic [319:0] s_in, input int a);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [7:0]  o;
        {x[0], x[1], x[2], x[3], x[4]} = s_in;
        for (int r = 12 - a; r < 12; r++) begin
            x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
            for (int i = 0; i < 64; i++) begin
                col = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
                o = sbox_t[col];
                y[0][i] = o[4];
                y[1][i] = o[3];
                y[2][i] = o[2];
                y[3][i] = o[1];
                y[4][i] = o[0];
            end
            x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
            x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
            x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
            x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
            x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_state(input logic [319:0] st);
        {xi[0], xi[1], xi[2], xi[3], xi[4]} = st;
    endtask

    // Records, per instance, the cycle after the accept edge at which out_valid rose.
    task automatic wait_results(input bit glitch, input logic [1:0] s);
        bit all_seen;
        for (int u = 0; u < 4; u++) begin
            lat[u] = 0;
            got[u] = '0;
        end
        for (int c = 1; c <= 16; c++) begin
            if (glitch && c == 1) begin
                in_valid = 1'b1;
                sel = ~s;
                for (int k = 0; k < 5; k++) xi[k] = ~xi[k];
            end
            if (glitch && c == 2) begin
                in_valid = 1'b0;
                sel = s;
            end
            cyc();
            all_seen = 1'b1;
            for (int u = 0; u < 4; u++) begin
                if (out_valid[u] && lat[u] == 0) begin
                    lat[u] = c;
                    got[u] = {xo[u][0], xo[u][1], xo[u][2], xo[u][3], xo[u][4]};
                end
                if (lat[u] == 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
    endtask

    task automatic run_txn(input logic [1:0] s, input logic [319:0] st, input bit glitch);
        sel = s;
        drive_state(st);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_results(glitch, s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel = 2'b00;
        drive_state('0);
        cyc();
        cyc();
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || busy[u] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ctrl u%0d: got rdy=%b vld=%b busy=%b want 1 0 0",
                         u, in_ready[u], out_valid[u], busy[u]);
            end
            n_vec++;
            if ({xo[u][0], xo[u][1], xo[u][2], xo[u][3], xo[u][4]} !== 320'd0) begin
                n_err++;
                $display("FAIL reset_state u%0d: got nonzero x*_o want 0", u);
            end
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_zero_p12();
        int exp_lat [4] = '{12, 6, 4, 3};
        logic [319:0] exp;
        exp = model_perm('0, 12);
        out_ready = 1'b1;
        run_txn(2'b00, '0, 1'b0);
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (lat[u] !== exp_lat[u]) begin
                n_err++;
                $display("FAIL zero_p12_latency u%0d: got %0d want %0d", u, lat[u], exp_lat[u]);
            end
            n_vec++;
            if (got[u] !== exp) begin
                n_err++;
                $display("FAIL zero_p12_result u%0d: got %h want %h", u, got[u], exp);
            end
        end
        cyc();
    endtask

    task automatic test_init_state();
        int exp_lat [4] = '{12, 6, 4, 3};
        logic [319:0] st, exp;
        st = {64'h80400c0600000000, 256'd0};
        exp = model_perm(st, 12);
        out_ready = 1'b1;
        run_txn(2'b11, st, 1'b0);
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (lat[u] !== exp_lat[u]) begin
                n_err++;
                $display("FAIL init_latency u%0d: got %0d want %0d", u, lat[u], exp_lat[u]);
            end
            n_vec++;
            if (got[u] !== exp) begin
                n_err++;
                $display("FAIL init_result u%0d: got %h want %h", u, got[u], exp);
            end
        end
        cyc();
    endtask

    task automatic test_p6();
        int exp_lat [4] = '{6, 3, 2, 2};
        logic [319:0] st, exp;
        for (int k = 0; k < 10; k++) st[k*32 +: 32] = $urandom;
        exp = model_perm(st, 6);
        out_ready = 1'b1;
        run_txn(2'b10, st, 1'b0);
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (lat[u] !== exp_lat[u]) begin
                n_err++;
                $display("FAIL p6_latency u%0d: got %0d want %0d", u, lat[u], exp_lat[u]);
            end
            n_vec++;
            if (got[u] !== exp) begin
                n_err++;
                $display("FAIL p6_result u%0d: got %h want %h", u, got[u], exp);
            end
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        int exp_lat8 [4] = '{8, 4, 3, 2};
        int exp_lat12 [4] = '{12, 6, 4, 3};
        logic [319:0] st_a, st_b, exp_a, exp_b;
        st_a = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h00000000ffffffff,
                64'h5555aaaa5555aaaa, 64'h1000000000000001};
        st_b = {64'hdeadbeefcafef00d, 64'h0, 64'h1, 64'h8000000000000000, 64'h3c3c3c3c3c3c3c3c};
        exp_a = model_perm(st_a, 8);
        exp_b = model_perm(st_b, 12);
        out_ready = 1'b0;
        run_txn(2'b01, st_a, 1'b0);
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (lat[u] !== exp_lat8[u]) begin
                n_err++;
                $display("FAIL hold_latency u%0d: got %0d want %0d", u, lat[u], exp_lat8[u]);
            end
        end
        for (int c = 0; c < 5; c++) begin
            cyc();
            for (int u = 0; u < 4; u++) begin
                n_vec++;
                if (out_valid[u] !== 1'b1 || in_ready[u] !== 1'b0 ||
                    {xo[u][0], xo[u][1], xo[u][2], xo[u][3], xo[u][4]} !== exp_a) begin
                    n_err++;
                    $display("FAIL hold_stable c%0d u%0d: got vld=%b rdy=%b x=%h want 1 0 %h",
                             c, u, out_valid[u], in_ready[u],
                             {xo[u][0], xo[u][1], xo[u][2], xo[u][3], xo[u][4]}, exp_a);
                end
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        sel = 2'b00;
        drive_state(st_b);
        #1;
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (in_ready[u] !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready u%0d: got %b want 1", u, in_ready[u]);
            end
        end
        cyc();
        in_valid = 1'b0;
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (busy[u] !== 1'b1 || out_valid[u] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_run u%0d: got busy=%b vld=%b want 1 0", u, busy[u], out_valid[u]);
            end
        end
        wait_results(1'b0, 2'b00);
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (lat[u] !== exp_lat12[u]) begin
                n_err++;
                $display("FAIL b2b_latency u%0d: got %0d want %0d", u, lat[u], exp_lat12[u]);
            end
            n_vec++;
            if (got[u] !== exp_b) begin
                n_err++;
                $display("FAIL b2b_result u%0d: got %h want %h", u, got[u], exp_b);
            end
        end
        cyc();
    endtask

    task automatic test_run_glitch();
        int exp_lat [4] = '{8, 4, 3, 2};
        logic [319:0] st, exp;
        st = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100, 64'h1111111111111111,
              64'h2222222222222222, 64'h4444444444444444};
        exp = model_perm(st, 8);
        out_ready = 1'b1;
        run_txn(2'b01, st, 1'b1);
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (lat[u] !== exp_lat[u]) begin
                n_err++;
                $display("FAIL glitch_latency u%0d: got %0d want %0d", u, lat[u], exp_lat[u]);
            end
            n_vec++;
            if (got[u] !== exp) begin
                n_err++;
                $display("FAIL glitch_result u%0d: got %h want %h", u, got[u], exp);
            end
        end
        cyc();
        cyc();
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (busy[u] !== 1'b0 || out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1) begin
                n_err++;
                $display("FAIL glitch_idle u%0d: got busy=%b vld=%b rdy=%b want 0 0 1",
                         u, busy[u], out_valid[u], in_ready[u]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int exp_lat [4] = '{8, 4, 3, 2};
        logic [319:0] st, exp;
        st = {64'h8877665544332211, 64'h99aabbccddeeff00, 64'h0, 64'hffffffffffffffff,
              64'h0123012301230123};
        exp = model_perm(st, 8);
        out_ready = 1'b1;
        sel = 2'b00;
        drive_state(st);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || busy[u] !== 1'b0 ||
                {xo[u][0], xo[u][1], xo[u][2], xo[u][3], xo[u][4]} !== 320'd0) begin
                n_err++;
                $display("FAIL midrun_reset u%0d: got rdy=%b vld=%b busy=%b want 1 0 0 and x*_o=0",
                         u, in_ready[u], out_valid[u], busy[u]);
            end
        end
        cyc();
        rst = 1'b0;
        cyc();
        run_txn(2'b01, st, 1'b0);
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (lat[u] !== exp_lat[u]) begin
                n_err++;
                $display("FAIL after_reset_latency u%0d: got %0d want %0d", u, lat[u], exp_lat[u]);
            end
            n_vec++;
            if (got[u] !== exp) begin
                n_err++;
                $display("FAIL after_reset_result u%0d: got %h want %h", u, got[u], exp);
            end
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_zero_p12();
        test_init_state();
        test_p6();
        test_back_to_back();
        test_run_glitch();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
